// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace producer: record layout, flag positions and FSM states.
package trace_pkg;

  localparam int REC_W = 71;

  // Flag nibble sits at the top of the record: {halt, wr, rd, rw}
  localparam int FLAG_RW   = 0;
  localparam int FLAG_RD   = 1;
  localparam int FLAG_WR   = 2;
  localparam int FLAG_HALT = 3;

  localparam int PC_LSB    = 0;
  localparam int MDATA_LSB = 16;
  localparam int ADDR_LSB  = 32;
  localparam int WDATA_LSB = 48;
  localparam int WREG_LSB  = 64;
  localparam int FLAGS_LSB = 67;

  localparam int REC_HALT_BIT = FLAGS_LSB + FLAG_HALT;

  typedef struct packed {
    logic [3:0]  flags;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
    logic [15:0] pc;
  } traceRec_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT_PEND,
    ST_DRAIN,
    ST_DONE
  } traceState_t;

  function automatic traceRec_t packRec(
    input logic        halt,
    input logic        wr,
    input logic        rd,
    input logic        rw,
    input logic [2:0]  wreg,
    input logic [15:0] wdata,
    input logic [15:0] addr,
    input logic [15:0] mdata,
    input logic [15:0] pc
  );
    traceRec_t r;
    r.flags            = '0;
    r.flags[FLAG_HALT] = halt;
    r.flags[FLAG_WR]   = wr;
    r.flags[FLAG_RD]   = rd;
    r.flags[FLAG_RW]   = rw;
    r.wreg             = wreg;
    r.wdata            = wdata;
    r.addr             = addr;
    r.mdata            = mdata;
    r.pc               = pc;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the commit-trace link; wrap-bit pointers, accepts a push while full if a pop
// happens on the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = REC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign popData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit-trace producer: packs retire events into records, buffers and streams them to the sink.
// Optional cache-event counters are built when TRACE_PERF_CNT_EN is defined.
module commit_trace_tx
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_regwrite,
  input  logic [2:0]       ev_wreg,
  input  logic [15:0]      ev_wdata,
  input  logic             ev_memread,
  input  logic             ev_memwrite,
  input  logic [15:0]      ev_addr,
  input  logic [15:0]      ev_mdata,
  input  logic [15:0]      ev_pc,
  input  logic             ev_halt,
`ifdef TRACE_PERF_CNT_EN
  input  logic             ev_dhit,
  input  logic             ev_ihit,
  input  logic             ev_dreq,
  input  logic             ev_ireq,
  output logic [CNT_W-1:0] dhit_cnt,
  output logic [CNT_W-1:0] ihit_cnt,
  output logic [CNT_W-1:0] dreq_cnt,
  output logic [CNT_W-1:0] ireq_cnt,
`endif
  output logic             tr_valid,
  input  logic             tr_ready,
  output logic [REC_W-1:0] tr_rec,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  traceState_t      state;
  traceState_t      nextState;
  traceRec_t        evRec;
  traceRec_t        pendRec;
  traceRec_t        pushData;
  logic [REC_W-1:0] fifoHead;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             evActive;
  logic             pop;
  logic             space;
  logic             push;
  logic             pendLoad;
  logic             dropEv;

  assign evRec = packRec(ev_halt, ev_memwrite, ev_memread, ev_regwrite,
                         ev_wreg, ev_wdata, ev_addr, ev_mdata, ev_pc);

  assign evActive = ev_regwrite | ev_memread | ev_memwrite | ev_halt;
  assign tr_valid = !fifoEmpty;
  assign tr_rec   = tr_valid ? fifoHead : '0;
  assign pop      = tr_valid && tr_ready;
  assign space    = !fifoFull || pop;
  assign done     = (state == ST_DONE);

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= nextState;
  end

  // A halt that finds the FIFO full parks here until a slot opens; it is never dropped.
  always_comb begin
    nextState = state;
    push      = 1'b0;
    pushData  = evRec;
    pendLoad  = 1'b0;
    dropEv    = 1'b0;
    case (state)
      ST_RUN: begin
        if (evActive) begin
          if (ev_halt) begin
            if (space) begin
              push      = 1'b1;
              nextState = ST_DRAIN;
            end else begin
              pendLoad  = 1'b1;
              nextState = ST_HALT_PEND;
            end
          end else if (space) begin
            push = 1'b1;
          end else begin
            dropEv = 1'b1;
          end
        end
      end
      ST_HALT_PEND: begin
        pushData = pendRec;
        if (space) begin
          push      = 1'b1;
          nextState = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && fifoHead[REC_HALT_BIT]) nextState = ST_DONE;
      end
      ST_DONE: begin
        nextState = ST_DONE;
      end
      default: begin
        nextState = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        pendRec <= '0;
    else if (pendLoad) pendRec <= evRec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (state != ST_DONE) cycle_cnt <= satInc(cycle_cnt);
      if (state == ST_RUN) begin
        if (ev_halt | ev_regwrite | ev_memwrite) inst_cnt <= satInc(inst_cnt);
        if (dropEv) begin
          drop_cnt <= satInc(drop_cnt);
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef TRACE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dhit_cnt <= '0;
      ihit_cnt <= '0;
      dreq_cnt <= '0;
      ireq_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (ev_dhit) dhit_cnt <= satInc(dhit_cnt);
      if (ev_ihit) ihit_cnt <= satInc(ihit_cnt);
      if (ev_dreq) dreq_cnt <= satInc(dreq_cnt);
      if (ev_ireq) ireq_cnt <= satInc(ireq_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: table of single-record vectors plus hand-written
// overflow, halt-drain and reset sequences.
module tb_commit_trace_tx;

  localparam int RW = 71;

  typedef struct {
    logic          rw;
    logic [2:0]    wreg;
    logic [15:0]   wdata;
    logic          rd;
    logic          wr;
    logic [15:0]   addr;
    logic [15:0]   mdata;
    logic [15:0]   pc;
    logic          expValid;
    logic [RW-1:0] expRec;
    string         name;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          ev_regwrite;
  logic [2:0]    ev_wreg;
  logic [15:0]   ev_wdata;
  logic          ev_memread;
  logic          ev_memwrite;
  logic [15:0]   ev_addr;
  logic [15:0]   ev_mdata;
  logic [15:0]   ev_pc;
  logic          ev_halt;
  logic          tr_valid;
  logic          tr_ready;
  logic [RW-1:0] tr_rec;
  logic          overflow;
  logic [31:0]   drop_cnt;
  logic [31:0]   cycle_cnt;
  logic [31:0]   inst_cnt;
  logic          done;
`ifdef TRACE_PERF_CNT_EN
  logic          ev_dhit, ev_ihit, ev_dreq, ev_ireq;
  logic [31:0]   dhit_cnt, ihit_cnt, dreq_cnt, ireq_cnt;
`endif

  int            total;
  int            bad;
  logic [31:0]   expCycle;
  logic [31:0]   expInst;
  logic          expFrozen;
  vec_t          vecs[6];
  logic [RW-1:0] expQ[$];
  logic [RW-1:0] haltRec;
  logic [15:0]   idx;

  commit_trace_tx #(.DEPTH(8), .CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ev_regwrite (ev_regwrite),
    .ev_wreg     (ev_wreg),
    .ev_wdata    (ev_wdata),
    .ev_memread  (ev_memread),
    .ev_memwrite (ev_memwrite),
    .ev_addr     (ev_addr),
    .ev_mdata    (ev_mdata),
    .ev_pc       (ev_pc),
    .ev_halt     (ev_halt),
`ifdef TRACE_PERF_CNT_EN
    .ev_dhit     (ev_dhit),
    .ev_ihit     (ev_ihit),
    .ev_dreq     (ev_dreq),
    .ev_ireq     (ev_ireq),
    .dhit_cnt    (dhit_cnt),
    .ihit_cnt    (ihit_cnt),
    .dreq_cnt    (dreq_cnt),
    .ireq_cnt    (ireq_cnt),
`endif
    .tr_valid    (tr_valid),
    .tr_ready    (tr_ready),
    .tr_rec      (tr_rec),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .cycle_cnt   (cycle_cnt),
    .inst_cnt    (inst_cnt),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference cycle counter: counts every non-reset edge until the trace is known complete.
  always @(posedge clk) begin
    if (!rst_n)          expCycle <= '0;
    else if (!expFrozen) expCycle <= expCycle + 32'd1;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [RW-1:0] storeRec(input logic [15:0] n);
    logic [15:0] a, m, p;
    a = 16'h0100 + n;
    m = 16'h2000 + n;
    p = 16'h0300 + n;
    return {4'b0100, 3'd0, 16'h0000, a, m, p};
  endfunction

  task automatic applyStimulus(input logic rw, input logic [2:0] wreg, input logic [15:0] wdata,
                               input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] mdata, input logic [15:0] pc,
                               input logic halt, input logic ready);
    ev_regwrite = rw;
    ev_wreg     = wreg;
    ev_wdata    = wdata;
    ev_memread  = rd;
    ev_memwrite = wr;
    ev_addr     = addr;
    ev_mdata    = mdata;
    ev_pc       = pc;
    ev_halt     = halt;
    tr_ready    = ready;
  endtask

  task automatic checkOutput(input string name, input logic [RW-1:0] actual,
                             input logic [RW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    expInst   = '0;
    expFrozen = 1'b0;
    rst_n     = 1'b0;
`ifdef TRACE_PERF_CNT_EN
    ev_dhit = 1'b0; ev_ihit = 1'b0; ev_dreq = 1'b0; ev_ireq = 1'b0;
`endif
    applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);

    vecs[0] = '{1'b1, 3'd3, 16'h00AA, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 1'b1,
                {4'b0001, 3'd3, 16'h00AA, 16'h0000, 16'h0000, 16'h0010}, "regwr_r3"};
    vecs[1] = '{1'b1, 3'd5, 16'h1234, 1'b1, 1'b0, 16'h0040, 16'h1234, 16'h0014, 1'b1,
                {4'b0011, 3'd5, 16'h1234, 16'h0040, 16'h1234, 16'h0014}, "load_regwr"};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 16'h0080, 16'h5555, 16'h0018, 1'b1,
                {4'b0010, 3'd0, 16'h0000, 16'h0080, 16'h5555, 16'h0018}, "load_only"};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 16'h00C0, 16'hA5A5, 16'h001C, 1'b1,
                {4'b0100, 3'd0, 16'h0000, 16'h00C0, 16'hA5A5, 16'h001C}, "store"};
    vecs[4] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 1'b0,
                71'd0, "idle"};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 16'h0100, 16'h0F0F, 16'h0024, 1'b1,
                {4'b0110, 3'd0, 16'h0000, 16'h0100, 16'h0F0F, 16'h0024}, "rd_and_wr"};

    tick();
    tick();
    checkOutput("rst_valid", tr_valid, 0);
    checkOutput("rst_rec", tr_rec, 0);
    checkOutput("rst_cycle", cycle_cnt, 0);
    checkOutput("rst_inst", inst_cnt, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_done", done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].rw, vecs[i].wreg, vecs[i].wdata, vecs[i].rd, vecs[i].wr,
                    vecs[i].addr, vecs[i].mdata, vecs[i].pc, 1'b0, 1'b1);
      tick();
      if (vecs[i].rw || vecs[i].wr) expInst = expInst + 32'd1;
      checkOutput({vecs[i].name, "_valid"}, tr_valid, vecs[i].expValid);
      checkOutput({vecs[i].name, "_rec"}, tr_rec, vecs[i].expRec);
      checkOutput({vecs[i].name, "_inst"}, inst_cnt, expInst);
      applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
      tick();
      checkOutput({vecs[i].name, "_popped"}, tr_valid, 0);
    end
    checkOutput("table_cycle", cycle_cnt, expCycle);

    // Ten stores into an eight-deep FIFO with the sink stalled
    for (int i = 0; i < 10; i++) begin
      idx = 16'(i);
      applyStimulus(0, 3'd0, 16'h0, 0, 1, 16'h0100 + idx, 16'h2000 + idx, 16'h0300 + idx, 0, 0);
      tick();
      expInst = expInst + 32'd1;
      if (i == 7) begin
        checkOutput("fill8_overflow", overflow, 0);
        checkOutput("fill8_drop", drop_cnt, 0);
      end
      if (i == 8) begin
        checkOutput("fill9_overflow", overflow, 1);
        checkOutput("fill9_drop", drop_cnt, 1);
      end
    end
    applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
    checkOutput("ovf_valid", tr_valid, 1);
    checkOutput("ovf_head", tr_rec, storeRec(16'd0));
    checkOutput("ovf_overflow", overflow, 1);
    checkOutput("ovf_drop", drop_cnt, 2);
    checkOutput("ovf_inst", inst_cnt, expInst);
    checkOutput("ovf_cycle", cycle_cnt, expCycle);

    // Pop and push on the same edge while full: no drop
    applyStimulus(0, 3'd0, 16'h0, 0, 1, 16'h010A, 16'h200A, 16'h030A, 0, 1);
    tick();
    expInst = expInst + 32'd1;
    applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
    checkOutput("popush_drop", drop_cnt, 2);
    checkOutput("popush_head", tr_rec, storeRec(16'd1));
    checkOutput("popush_inst", inst_cnt, expInst);

    // Halt while full parks in HALT_PEND; later events are ignored
    haltRec = {4'b1000, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF};
    applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'hBEEF, 1, 0);
    tick();
    expInst = expInst + 32'd1;
    checkOutput("hpend_inst", inst_cnt, expInst);
    checkOutput("hpend_done", done, 0);
    checkOutput("hpend_head", tr_rec, storeRec(16'd1));
    applyStimulus(1, 3'd1, 16'h7777, 0, 0, 16'h0, 16'h0, 16'h0044, 0, 0);
    tick();
    checkOutput("hpend_ignore_inst", inst_cnt, expInst);
    checkOutput("hpend_ignore_drop", drop_cnt, 2);
    checkOutput("hpend_valid", tr_valid, 1);

    expQ.delete();
    for (int i = 1; i < 8; i++) expQ.push_back(storeRec(16'(i)));
    expQ.push_back(storeRec(16'd10));
    expQ.push_back(haltRec);
    for (int k = 0; k < 9; k++) begin
      if (k == 3) applyStimulus(0, 3'd0, 16'h0, 0, 1, 16'h0555, 16'h0666, 16'h0048, 0, 1);
      else        applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
      checkOutput($sformatf("drain%0d_valid", k), tr_valid, 1);
      checkOutput($sformatf("drain%0d_rec", k), tr_rec, expQ[k]);
      if (k == 8) checkOutput("drain_done_early", done, 0);
      tick();
    end
    expFrozen = 1'b1;
    applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 1);
    checkOutput("done_set", done, 1);
    checkOutput("done_valid", tr_valid, 0);
    checkOutput("done_inst", inst_cnt, expInst);
    checkOutput("done_drop", drop_cnt, 2);
    repeat (3) tick();
    checkOutput("done_cycle_frozen", cycle_cnt, expCycle);
    checkOutput("done_held", done, 1);

    // Reset clears sticky state, then reset again with a record in flight
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    expFrozen = 1'b0;
    expInst   = '0;
    checkOutput("rst2_done", done, 0);
    checkOutput("rst2_overflow", overflow, 0);
    checkOutput("rst2_drop", drop_cnt, 0);
    checkOutput("rst2_cycle", cycle_cnt, expCycle);
    applyStimulus(1, 3'd2, 16'hCAFE, 0, 0, 16'h0, 16'h0, 16'h0050, 0, 0);
    tick();
    expInst = expInst + 32'd1;
    checkOutput("midrst_pre_valid", tr_valid, 1);
    checkOutput("midrst_pre_rec", tr_rec, {4'b0001, 3'd2, 16'hCAFE, 16'h0000, 16'h0000, 16'h0050});
    checkOutput("midrst_pre_inst", inst_cnt, expInst);
    applyStimulus(0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 0);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_valid", tr_valid, 0);
    checkOutput("midrst_rec", tr_rec, 0);
    checkOutput("midrst_inst", inst_cnt, 0);
    checkOutput("midrst_cycle", cycle_cnt, 0);
    checkOutput("midrst_overflow", overflow, 0);
    checkOutput("midrst_done", done, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
